// File: rtl/core_status_dumper.sv
// -----------------------------------------------------------------------------
// core_status_dumper
//
// Purpose:
//   On a rising edge of the core's "completed" level, capture the core program
//   counter, the three branch-prediction counters and the low NUM_REGS
//   architectural registers into a shadow copy. Then stream that copy as one
//   byte-wide frame over a valid/ready handshake:
//       HEADER, pc, preds[0..2], regs[0..NUM_REGS-1], checksum
//   Words go out little-endian. The checksum is the 8-bit sum of every word
//   byte; the header byte is not included.
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rstn       in   1      asynchronous active-low reset
//   completed  in   1      core run finished (level)
//   pc         in   32     core program counter
//   preds      in   96     {fail, succeed, total} prediction counts, total in [31:0]
//   regs       in   1024   register file, regs[i] in bits [32*i+31:32*i]
//   tx_data    out  8      frame byte
//   tx_valid   out  1      tx_data valid
//   tx_ready   in   1      sink accepts a byte when tx_valid & tx_ready at an edge
//   dump_busy  out  1      frame in progress
//   dump_done  out  1      frame fully sent, held while completed stays high
// -----------------------------------------------------------------------------
module core_status_dumper #(
    parameter int          NUM_REGS = 16,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          completed,
    input  logic [31:0]   pc,
    input  logic [95:0]   preds,
    input  logic [1023:0] regs,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          dump_busy,
    output logic          dump_done
);

    localparam int NUM_WORDS = 4 + NUM_REGS;
    localparam int WIDX_W    = $clog2(NUM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WORD,
        S_SUM,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                completed_q;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          sum_q, sum_d;

    logic [31:0]         snap_q   [NUM_WORDS];
    logic [31:0]         snap_src [NUM_WORDS];

    logic                trigger;
    logic                accept;
    logic                last_byte;
    logic [31:0]         cur_word;
    logic [7:0]          cur_byte;

    // Frame word order: pc, preds[0..2], regs[0..NUM_REGS-1].
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_src
            if (gi == 0) begin : g_pc
                assign snap_src[gi] = pc;
            end else if (gi < 4) begin : g_pred
                assign snap_src[gi] = preds[32*(gi-1) +: 32];
            end else begin : g_reg
                assign snap_src[gi] = regs[32*(gi-4) +: 32];
            end
        end
        // Registers above NUM_REGS are intentionally not dumped.
        if (NUM_REGS < 32) begin : g_unused
            logic unused_regs;
            assign unused_regs = ^regs[1023:32*NUM_REGS];
        end
    endgenerate

    // Rising edge of completed, only honoured while idle; completed_q resets
    // low so a level already high out of reset triggers at the first edge.
    assign trigger   = (state_q == S_IDLE) && completed && !completed_q;
    assign accept    = tx_valid && tx_ready;
    assign last_byte = (byte_idx_q == 2'd3) &&
                       (word_idx_q == WIDX_W'(NUM_WORDS - 1));

    assign cur_word  = snap_q[word_idx_q];
    assign cur_byte  = cur_word[{byte_idx_q, 3'b000} +: 8];

    // Outputs are decoded from registered state; indices only move on a
    // handshake, so tx_data is stable while a byte is stalled.
    always_comb begin
        tx_valid  = 1'b0;
        dump_busy = 1'b0;
        dump_done = 1'b0;
        tx_data   = 8'h00;
        case (state_q)
            S_HDR: begin
                tx_valid  = 1'b1;
                dump_busy = 1'b1;
                tx_data   = HEADER;
            end
            S_WORD: begin
                tx_valid  = 1'b1;
                dump_busy = 1'b1;
                tx_data   = cur_byte;
            end
            S_SUM: begin
                tx_valid  = 1'b1;
                dump_busy = 1'b1;
                tx_data   = sum_q;
            end
            S_DONE: begin
                dump_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        sum_d      = sum_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d    = S_HDR;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    sum_d      = 8'h00;
                end
            end
            S_HDR: begin
                if (accept) begin
                    state_d = S_WORD;
                end
            end
            S_WORD: begin
                if (accept) begin
                    sum_d      = sum_q + cur_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (last_byte) begin
                        state_d    = S_SUM;
                        word_idx_d = '0;
                    end else if (byte_idx_q == 2'd3) begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            S_SUM: begin
                // If completed already fell during the frame, skip DONE so the
                // trigger is re-armed straight away.
                if (accept) begin
                    state_d = completed ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (!completed) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            completed_q <= 1'b0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            sum_q       <= 8'h00;
        end else begin
            state_q     <= state_d;
            completed_q <= completed;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            sum_q       <= sum_d;
        end
    end

    // Shadow copy: the frame is built only from this, never from live inputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                snap_q[i] <= 32'h0;
            end
        end else if (trigger) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                snap_q[i] <= snap_src[i];
            end
        end
    end

endmodule

// File: tb/tb_core_status_dumper.sv
module tb_core_status_dumper;

    localparam int NREGS   = 16;
    localparam int NBYTES  = 2 + 4 * (4 + NREGS);

    logic          clk = 1'b0;
    logic          rstn;
    logic          completed;
    logic [31:0]   pc;
    logic [95:0]   preds;
    logic [1023:0] regs;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          dump_busy;
    logic          dump_done;

    logic [7:0]    exp_q [$];
    logic [7:0]    rx_q  [$];
    int            vectors    = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    core_status_dumper dut (
        .clk       (clk),
        .rstn      (rstn),
        .completed (completed),
        .pc        (pc),
        .preds     (preds),
        .regs      (regs),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dump_busy (dump_busy),
        .dump_done (dump_done)
    );

    // Advance to 1 time unit after the n-th next rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: expected frame for the current input values.
    task automatic push_frame();
        logic [31:0] w [4+NREGS];
        logic [7:0]  b;
        int          sum;
        w[0] = pc;
        for (int k = 0; k < 3; k++) w[1+k] = preds[32*k +: 32];
        for (int k = 0; k < NREGS; k++) w[4+k] = regs[32*k +: 32];
        exp_q.push_back(8'hA5);
        sum = 0;
        for (int k = 0; k < 4 + NREGS; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = w[k][8*j +: 8];
                exp_q.push_back(b);
                sum = (sum + int'(b)) % 256;
            end
        end
        exp_q.push_back(sum[7:0]);
    endtask

    // Raise completed and record the frame it is expected to produce.
    task automatic start_frame();
        completed = 1'b1;
        push_frame();
    endtask

    // Sink side: drives tx_ready, records accepted bytes into rx_q, counts
    // stalled bytes that changed or disappeared before being accepted.
    task automatic collect(input int nbytes, input int ready_pct, input int budget,
                           output int cycles, output int stall_err, output bit timeout);
        int         got;
        logic       pv, pr;
        logic [7:0] pd;
        got = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
        cycles = 0; stall_err = 0; timeout = 1'b0;
        while (got < nbytes) begin
            if (cycles >= budget) begin
                timeout = 1'b1;
                break;
            end
            tx_ready = ($urandom_range(99) < ready_pct);
            @(negedge clk);
            cycles++;
            if (pv && !pr && (!tx_valid || tx_data !== pd)) stall_err++;
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                got++;
            end
            tick(1);
        end
        tx_ready = 1'b0;
    endtask

    task automatic set_default_inputs();
        pc    = 32'h0000_0100;
        preds = {32'd3, 32'd7, 32'd10};
        regs  = '0;
        for (int i = 0; i < NREGS; i++) regs[32*i +: 32] = i;
    endtask

    task automatic test_reset();
        rstn = 1'b0; completed = 1'b0; tx_ready = 1'b0;
        set_default_inputs();
        tick(2);
        rstn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (tx_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || tx_data !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: valid=%b busy=%b done=%b data=%h, required 0 0 0 00",
                         c, tx_valid, dump_busy, dump_done, tx_data);
            end
        end
        tick(1);
        $display("reset: idle 20 cycles checked");
    endtask

    task automatic test_back_to_back();
        int cyc, stall; bit to;
        start_frame();
        collect(NBYTES, 100, 400, cyc, stall, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d bytes, required %0d", rx_q.size(), NBYTES);
        end
        vectors++;
        if (cyc !== NBYTES + 1) begin
            miscompares++;
            $display("FAIL b2b_cycles: took %0d cycles, required %0d", cyc, NBYTES + 1);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = rx_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL b2b_byte: got %h, required %h", g, e);
            end
        end
        vectors++;
        if (dump_done !== 1'b1 || dump_busy !== 1'b0 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: done=%b busy=%b valid=%b, required 1 0 0", dump_done, dump_busy, tx_valid);
        end
        exp_q.delete(); rx_q.delete();
        $display("frame back_to_back: %0d cycles", cyc);
    endtask

    task automatic test_random_ready();
        int cyc, stall; bit to;
        completed = 1'b0;
        tick(2);
        start_frame();
        collect(NBYTES, 50, 2000, cyc, stall, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL rand_timeout: got %0d bytes, required %0d", rx_q.size(), NBYTES);
        end
        vectors++;
        if (stall !== 0) begin
            miscompares++;
            $display("FAIL rand_stall_stable: %0d unstable stalls, required 0", stall);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = rx_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL rand_byte: got %h, required %h", g, e);
            end
        end
        exp_q.delete(); rx_q.delete();
        $display("frame random_ready: %0d cycles", cyc);
    endtask

    task automatic test_snapshot();
        int cyc, stall; bit to;
        completed = 1'b0;
        tick(2);
        pc    = 32'hDEAD_BEEF;
        preds = {32'h0000_0123, 32'h0001_0000, 32'hFFFF_FFFE};
        for (int i = 0; i < NREGS; i++) regs[32*i +: 32] = $urandom();
        tx_ready = 1'b0;
        start_frame();
        tick(1);
        // Trigger edge has passed; scramble the live inputs.
        pc    = ~pc;
        preds = ~preds;
        for (int i = 0; i < NREGS; i++) regs[32*i +: 32] = $urandom();
        collect(NBYTES, 70, 1000, cyc, stall, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL snap_timeout: got %0d bytes, required %0d", rx_q.size(), NBYTES);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = rx_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL snap_byte: got %h, required %h", g, e);
            end
        end
        exp_q.delete(); rx_q.delete();
        $display("frame snapshot: %0d cycles", cyc);
    endtask

    task automatic test_reset_mid_frame();
        int cyc, stall; bit to;
        completed = 1'b0;
        tick(2);
        set_default_inputs();
        start_frame();
        collect(30, 100, 200, cyc, stall, to);
        rstn = 1'b0;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || dump_busy !== 1'b0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_reset: valid=%b busy=%b data=%h, required 0 0 00", tx_valid, dump_busy, tx_data);
        end
        completed = 1'b0;
        exp_q.delete(); rx_q.delete();
        tick(2);
        rstn = 1'b1;
        tick(2);
        vectors++;
        if (tx_valid !== 1'b0 || dump_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: valid=%b done=%b, required 0 0", tx_valid, dump_done);
        end
        pc = 32'h1234_5678;
        start_frame();
        collect(NBYTES, 100, 400, cyc, stall, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL fresh_timeout: got %0d bytes, required %0d", rx_q.size(), NBYTES);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = rx_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL fresh_byte: got %h, required %h", g, e);
            end
        end
        exp_q.delete(); rx_q.delete();
        $display("frame after_reset: %0d cycles", cyc);
    endtask

    task automatic test_retrigger();
        int cyc, stall; bit to;
        int extra;
        // completed is still high and the FSM sits in DONE.
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || dump_done !== 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL hold_no_retrigger: %0d bad cycles, required 0", extra);
        end
        tick(1);
        completed = 1'b0;
        tick(1);
        vectors++;
        if (dump_done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_clear: done=%b, required 0", dump_done);
        end
        pc = 32'hCAFE_0001;
        start_frame();
        collect(NBYTES, 100, 400, cyc, stall, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL rearm_timeout: got %0d bytes, required %0d", rx_q.size(), NBYTES);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = rx_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL rearm_byte: got %h, required %h", g, e);
            end
        end
        exp_q.delete(); rx_q.delete();
        extra = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0) extra++;
        end
        tick(1);
        tx_ready = 1'b0;
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL single_frame: %0d valid cycles after frame, required 0", extra);
        end
        $display("frame rearm: %0d cycles", cyc);

        // Drop completed mid-frame: frame must still finish, then IDLE.
        completed = 1'b0;
        tick(1);
        pc = 32'h0BAD_F00D;
        start_frame();
        collect(10, 100, 100, cyc, stall, to);
        completed = 1'b0;
        collect(NBYTES - 10, 60, 1000, cyc, stall, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL drop_timeout: got %0d bytes, required %0d", rx_q.size(), NBYTES);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] e, g;
            e = exp_q.pop_front(); g = rx_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL drop_byte: got %h, required %h", g, e);
            end
        end
        exp_q.delete(); rx_q.delete();
        vectors++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_idle: done=%b busy=%b valid=%b, required 0 0 0", dump_done, dump_busy, tx_valid);
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || dump_done !== 1'b0) extra++;
        end
        tick(1);
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL drop_stay_idle: %0d bad cycles, required 0", extra);
        end
        $display("frame completed_dropped: done");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_ready();
        test_snapshot();
        test_reset_mid_frame();
        test_retrigger();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
